stacker_row_mover: RTL and testbench
====================================

// Module: stacker_row_mover
// PURPOSE
//  Parametrised successor to the single-block mover: sweeps a row of N blocks across the screen,
//  bouncing between x=0 and the right edge, and freezes on a player "stop" press. Owns its own step
//  timer, reports row left-edge x, width and direction to the draw datapath and game-control FSM.
// PARAMETERS
//  X_W          10   width of all x quantities (pixels)
//  SCREEN_W     640  visible width; row never exceeds SCREEN_W-1
//  BLOCK_W      48   width of one block; one step = BLOCK_W pixels
//  MAX_BLOCKS   3    largest row length accepted on num_blocks
//  NB_W         2    width of num_blocks (>= clog2(MAX_BLOCKS+1))
//  STEP_PERIOD  25'd5_000_000  clk cycles between steps
//  MIN_PERIOD   25'd1_000_000  floor for step period (speed-up only)
//  SPEED_STEP   25'd500_000    period decrement per launch (speed-up only)
// PORTS
//  clk         in   1      system clock
//  resetn      in   1      asynchronous active-low reset
//  enable      in   1      1 = timer runs; 0 = pause (state, x, counter held)
//  start       in   1      1-cycle pulse: launch/relaunch the row
//  stop        in   1      1-cycle pulse: freeze row (player press, pre-debounced)
//  num_blocks  in   NB_W   row length; sampled on start only
//  x_pos       out  X_W    left edge of row, pixels
//  row_w       out  X_W    num_blocks_latched*BLOCK_W
//  dir         out  1      0 = moving right, 1 = moving left
//  moving      out  1      high in MOVE_R/MOVE_L
//  stopped     out  1      high in STOPPED
//  stop_pulse  out  1      1-cycle strobe the cycle after entering STOPPED
// BEHAVIOUR
//  Reset: state=IDLE, x_pos=0, row_w=0, dir=0, moving=0, stopped=0, stop_pulse=0, counter=0,
//   period=STEP_PERIOD. All outputs registered.
//  FSM: IDLE -start-> MOVE_R. MOVE_R/MOVE_L -stop-> STOPPED. STOPPED -start-> MOVE_R (x kept).
//   start in MOVE_* ignored; stop in IDLE/STOPPED ignored; start+stop same cycle: stop wins in MOVE_*,
//   start wins in IDLE/STOPPED.
//  On start: latch nb = clamp(num_blocks, 1, MAX_BLOCKS) (0 -> 1); row_w = nb*BLOCK_W;
//   limit = SCREEN_W - row_w; counter cleared; dir=0.
//  Timer: counts only in MOVE_* with enable=1; step event when counter==period-1, counter -> 0.
//  Step in MOVE_R: if x_pos+BLOCK_W <= limit then x_pos += BLOCK_W else {state=MOVE_L, dir=1,
//   x_pos -= BLOCK_W if x_pos>=BLOCK_W else hold}. MOVE_L symmetric: if x_pos>=BLOCK_W then
//   x_pos -= BLOCK_W else {state=MOVE_R, dir=0, x_pos += BLOCK_W if x_pos+BLOCK_W<=limit else hold}.
//   Bounce costs no extra step; x never leaves [0, limit]. limit<BLOCK_W -> x_pos stays 0, dir toggles.
//  Arithmetic done at X_W+1 bits to avoid wrap; x_pos <= limit always holds.
//  Stop and step event same cycle: stop wins, x_pos not updated.
//  Reset mid-sweep: immediate return to reset values, no stop_pulse.
// CONFIGURATION
//  `STACKER_SPEEDUP_EN defined: each start from STOPPED sets
//   period = max(period-SPEED_STEP, MIN_PERIOD); start from IDLE restores STEP_PERIOD.
//  Not defined: period fixed at STEP_PERIOD; MIN_PERIOD/SPEED_STEP unused.
// STRUCTURE
//  stacker_pkg: state enum {IDLE, MOVE_R, MOVE_L, STOPPED}, DIR_RIGHT/DIR_LEFT constants.
//  One sub-module: stacker_step_timer (counter, run, period in -> step strobe; clear input).
//  FSM, limit calculation and x register live in the top module.
// TESTING  (bench: STEP_PERIOD=4, MIN_PERIOD=2, SPEED_STEP=1, defaults otherwise)
//  1 reset, start, nb=3 -> row_w=144, x_pos 0,48,...,480, then 432 with dir=1, step every 4 clk.
//  2 left bounce: continue -> x_pos reaches 0, next step x_pos=48 and dir=0.
//  3 stop at x=240 -> stopped=1, stop_pulse high exactly 1 cycle, x_pos holds 240 for 20 cycles.
//  4 stop and step coincide -> x_pos unchanged; enable=0 for 10 cycles -> counter/x frozen.
//  5 nb=0 -> row_w=48, limit=592, peak x=576; nb=7 -> clamped to 3, row_w=144.
//  6 SPEEDUP_EN: three stop/start cycles -> step spacing 3,2,2 clk; resetn low mid-sweep -> x_pos=0.

Source files
------------

// File: rtl/stacker_pkg.sv
// Shared types for the stacker row mover.
// Holds the FSM state encoding and direction constants.
package stacker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_R,
    MOVE_L,
    STOPPED
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  localparam int   PERIOD_W  = 25;

endpackage

// File: rtl/stacker_row_mover_if.sv
// Control/status bundle between game control and the row mover.
// master drives controls, slave (the mover) drives row status.
interface stacker_row_mover_if #(
  parameter int X_W  = 10,
  parameter int NB_W = 2
);

  logic            enable;
  logic            start;
  logic            stop;
  logic [NB_W-1:0] num_blocks;
  logic [X_W-1:0]  x_pos;
  logic [X_W-1:0]  row_w;
  logic            dir;
  logic            moving;
  logic            stopped;
  logic            stop_pulse;

  modport master (
    output enable, start, stop, num_blocks,
    input  x_pos, row_w, dir, moving, stopped, stop_pulse
  );

  modport slave (
    input  enable, start, stop, num_blocks,
    output x_pos, row_w, dir, moving, stopped, stop_pulse
  );

endinterface

// File: rtl/stacker_step_timer.sv
// Free-running step divider: strobes step when count hits period-1.
// clear restarts the count; run gates counting.
module stacker_step_timer #(
  parameter int P_W = 25
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic           clear,
  input  logic [P_W-1:0] period,
  output logic           step
);

  localparam logic [P_W-1:0] ONE = P_W'(1);

  logic [P_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == period - ONE) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stacker_row_mover.sv
// Sweeps a row of blocks between x=0 and the right edge, freezing on stop.
// Define STACKER_SPEEDUP_EN to shorten the step period on each relaunch.
module stacker_row_mover
  import stacker_pkg::*;
#(
  parameter int                  X_W         = 10,
  parameter int                  SCREEN_W    = 640,
  parameter int                  BLOCK_W     = 48,
  parameter int                  MAX_BLOCKS  = 3,
  parameter int                  NB_W        = 2,
  parameter logic [PERIOD_W-1:0] STEP_PERIOD = 25'd5_000_000,
  parameter logic [PERIOD_W-1:0] MIN_PERIOD  = 25'd1_000_000,
  parameter logic [PERIOD_W-1:0] SPEED_STEP  = 25'd500_000
) (
  input logic                clk,
  input logic                resetn,
  stacker_row_mover_if.slave io
);

`ifdef STACKER_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  localparam logic [X_W:0]    BW     = (X_W+1)'(BLOCK_W);
  localparam logic [X_W:0]    SW     = (X_W+1)'(SCREEN_W);
  localparam logic [NB_W-1:0] NB_ONE = NB_W'(1);
  localparam logic [NB_W-1:0] NB_MAX = NB_W'(MAX_BLOCKS);

  state_e              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [X_W-1:0]      row_w_q, row_w_d;
  logic                dir_q, dir_d;
  logic                moving_q, moving_d;
  logic                stopped_q, stopped_d;
  logic                pulse_q, pulse_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] faster;

  logic            step, run, clr;
  logic [NB_W-1:0] nb;
  logic [X_W:0]    x_ext, x_fwd, limit, row_new, limit_new;
  logic [X_W-1:0]  x_back;
  logic            fits_r, fits_l;

  always_comb begin
    nb = io.num_blocks;
    unique case (1'b1)
      (io.num_blocks == '0):   nb = NB_ONE;
      (io.num_blocks > NB_MAX): nb = NB_MAX;
      default: ;
    endcase
  end

  // All x math is one bit wider so x+BLOCK_W cannot wrap.
  assign row_new   = {{(X_W+1-NB_W){1'b0}}, nb} * BW;
  assign limit_new = SW - row_new;
  assign limit     = SW - {1'b0, row_w_q};
  assign x_ext     = {1'b0, x_q};
  assign x_fwd     = x_ext + BW;
  assign x_back    = x_q - BW[X_W-1:0];
  assign fits_r    = (x_fwd <= limit);
  assign fits_l    = (x_ext >= BW);

  assign faster = (period_q - MIN_PERIOD >= SPEED_STEP) ?
                  period_q - SPEED_STEP : MIN_PERIOD;

  assign run = io.enable &
               ((state_q == MOVE_R) | (state_q == MOVE_L));

  stacker_step_timer #(
    .P_W (PERIOD_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (resetn),
    .run    (run),
    .clear  (clr),
    .period (period_q),
    .step   (step)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    row_w_d  = row_w_q;
    dir_d    = dir_q;
    period_d = period_q;
    clr      = 1'b0;
    if (io.enable) begin
      unique case (state_q)
        IDLE, STOPPED: begin
          if (io.start) begin
            state_d = MOVE_R;
            dir_d   = DIR_RIGHT;
            row_w_d = row_new[X_W-1:0];
            clr     = 1'b1;
            // A wider row may no longer fit at the frozen x.
            if (x_ext > limit_new) x_d = limit_new[X_W-1:0];
            if (state_q == IDLE) period_d = STEP_PERIOD;
            else if (SPEEDUP)    period_d = faster;
          end
        end
        MOVE_R: begin
          if (io.stop) begin
            state_d = STOPPED;
          end else if (step) begin
            if (fits_r) begin
              x_d = x_fwd[X_W-1:0];
            end else begin
              state_d = MOVE_L;
              dir_d   = DIR_LEFT;
              if (fits_l) x_d = x_back;
            end
          end
        end
        MOVE_L: begin
          if (io.stop) begin
            state_d = STOPPED;
          end else if (step) begin
            if (fits_l) begin
              x_d = x_back;
            end else begin
              state_d = MOVE_R;
              dir_d   = DIR_RIGHT;
              if (fits_r) x_d = x_fwd[X_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
    moving_d  = (state_d == MOVE_R) | (state_d == MOVE_L);
    stopped_d = (state_d == STOPPED);
    pulse_d   = stopped_d & (state_q != STOPPED);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      x_q       <= '0;
      row_w_q   <= '0;
      dir_q     <= DIR_RIGHT;
      moving_q  <= 1'b0;
      stopped_q <= 1'b0;
      pulse_q   <= 1'b0;
      period_q  <= STEP_PERIOD;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      row_w_q   <= row_w_d;
      dir_q     <= dir_d;
      moving_q  <= moving_d;
      stopped_q <= stopped_d;
      pulse_q   <= pulse_d;
      period_q  <= period_d;
    end
  end

  assign io.x_pos      = x_q;
  assign io.row_w      = row_w_q;
  assign io.dir        = dir_q;
  assign io.moving     = moving_q;
  assign io.stopped    = stopped_q;
  assign io.stop_pulse = pulse_q;

endmodule

// File: tb/tb_stacker_row_mover.sv
// Bench for stacker_row_mover: directed table, corner sequences,
// then random stimulus against a position/direction model.
module tb_stacker_row_mover;

  localparam int TP   = 4;
  localparam int MINP = 2;
  localparam int SPD  = 1;
  localparam int BW   = 48;
  localparam int SW   = 640;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  stacker_row_mover_if #(.X_W(10), .NB_W(3)) io ();

  stacker_row_mover #(
    .STEP_PERIOD (25'd4),
    .MIN_PERIOD  (25'd2),
    .SPEED_STEP  (25'd1),
    .NB_W        (3)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (io)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit st;
    bit sp;
    int nb;
    int n;
    int x;
    int w;
    int dir;
    int mov;
    int stp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int next_per(input int p);
`ifdef STACKER_SPEEDUP_EN
    return (p - SPD < MINP) ? MINP : p - SPD;
`else
    return TP;
`endif
  endfunction

  task automatic do_reset();
    resetn        = 1'b0;
    io.enable     = 1'b1;
    io.start      = 1'b0;
    io.stop       = 1'b0;
    io.num_blocks = '0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      io.start      = vecs[i].st;
      io.stop       = vecs[i].sp;
      io.num_blocks = 3'(vecs[i].nb);
      tick();
      io.start = 1'b0;
      io.stop  = 1'b0;
      for (int k = 1; k < vecs[i].n; k++) tick();
      chk($sformatf("vec%0d.x", i), int'(io.x_pos), vecs[i].x);
      chk($sformatf("vec%0d.w", i), int'(io.row_w), vecs[i].w);
      chk($sformatf("vec%0d.dir", i), int'(io.dir), vecs[i].dir);
      chk($sformatf("vec%0d.mov", i), int'(io.moving), vecs[i].mov);
      chk($sformatf("vec%0d.stp", i), int'(io.stopped), vecs[i].stp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 moving, 2 stopped.
  int m_mode, m_x, m_dir, m_nb, m_cnt, m_per, m_pulse;

  task automatic model_reset();
    m_mode = 0; m_x = 0; m_dir = 0; m_nb = 0;
    m_cnt = 0; m_per = TP; m_pulse = 0;
  endtask

  task automatic model_move();
    int lim, d;
    lim = SW - m_nb * BW;
    d = m_dir ? -BW : BW;
    if (m_x + d < 0 || m_x + d > lim) begin
      m_dir = 1 - m_dir;
      d = -d;
      if (m_x + d >= 0 && m_x + d <= lim) m_x += d;
    end else begin
      m_x += d;
    end
  endtask

  task automatic model_clock(input bit st, input bit sp,
                             input bit en, input int nb);
    int lim;
    m_pulse = 0;
    if (!en) return;
    if (m_mode == 1) begin
      if (sp) begin
        m_mode = 2;
        m_pulse = 1;
      end else begin
        m_cnt++;
        if (m_cnt == m_per) begin
          m_cnt = 0;
          model_move();
        end
      end
    end else if (st) begin
      m_per = (m_mode == 0) ? TP : next_per(m_per);
      m_nb = (nb == 0) ? 1 : (nb > 3 ? 3 : nb);
      lim = SW - m_nb * BW;
      if (m_x > lim) m_x = lim;
      m_dir = 0;
      m_cnt = 0;
      m_mode = 1;
    end
  endtask

  initial begin
    int per, x0, c, bad, pulses;
    int exp_sp[3];
    bit st, sp, en;
    int nb, got, exp;

    vecs[0]  = '{1, 0, 3, 1,    0, 144, 0, 1, 0};
    vecs[1]  = '{0, 0, 3, 4,   48, 144, 0, 1, 0};
    vecs[2]  = '{0, 0, 3, 36, 480, 144, 0, 1, 0};
    vecs[3]  = '{0, 0, 3, 4,  432, 144, 1, 1, 0};
    vecs[4]  = '{0, 0, 3, 36,   0, 144, 1, 1, 0};
    vecs[5]  = '{0, 0, 3, 4,   48, 144, 0, 1, 0};
    vecs[6]  = '{0, 0, 3, 16, 240, 144, 0, 1, 0};
    vecs[7]  = '{1, 0, 0, 1,    0,  48, 0, 1, 0};
    vecs[8]  = '{0, 0, 0, 48, 576,  48, 0, 1, 0};
    vecs[9]  = '{0, 0, 0, 4,  528,  48, 1, 1, 0};
    vecs[10] = '{0, 1, 0, 1,  528,  48, 1, 0, 1};
    vecs[11] = '{1, 0, 7, 1,    0, 144, 0, 1, 0};

    do_reset();
    chk("rst.x", int'(io.x_pos), 0);
    chk("rst.w", int'(io.row_w), 0);
    chk("rst.dir", int'(io.dir), 0);
    chk("rst.mov", int'(io.moving), 0);
    chk("rst.stp", int'(io.stopped), 0);
    chk("rst.pulse", int'(io.stop_pulse), 0);

    // sweep right, bounce, sweep left, bounce, go to 240
    run_table(0, 6);
    per = TP;

    // stop at 240: pulse for one cycle, then hold
    io.stop = 1'b1;
    tick();
    io.stop = 1'b0;
    chk("stop.stp", int'(io.stopped), 1);
    chk("stop.pulse1", int'(io.stop_pulse), 1);
    tick();
    chk("stop.pulse2", int'(io.stop_pulse), 0);
    bad = 0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (io.x_pos != 10'd240) bad++;
      if (io.stop_pulse) pulses++;
    end
    chk("stop.hold240", bad, 0);
    chk("stop.nopulse", pulses, 0);

    // relaunch, then stop on the step edge
    io.start = 1'b1; io.num_blocks = 3'd3;
    tick();
    io.start = 1'b0;
    per = next_per(per);
    chk("relaunch.mov", int'(io.moving), 1);
    chk("relaunch.x", int'(io.x_pos), 240);
    for (int k = 1; k < per; k++) tick();
    chk("prestep.x", int'(io.x_pos), 240);
    io.stop = 1'b1;
    tick();
    io.stop = 1'b0;
    chk("stopstep.x", int'(io.x_pos), 240);
    chk("stopstep.stp", int'(io.stopped), 1);

    // pause mid-count
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    per = next_per(per);
    tick();
    io.enable = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("pause.x", int'(io.x_pos), 240);
    chk("pause.mov", int'(io.moving), 1);
    io.enable = 1'b1;
    for (int k = 0; k < per - 2; k++) tick();
    chk("unpause.pre", int'(io.x_pos), 240);
    tick();
    chk("unpause.step", int'(io.x_pos), 288);

    // single block row, then clamp of oversized num_blocks
    do_reset();
    run_table(7, 10);
    do_reset();
    run_table(11, 11);

    // step spacing across stop/start cycles
`ifdef STACKER_SPEEDUP_EN
    exp_sp = '{3, 2, 2};
`else
    exp_sp = '{4, 4, 4};
`endif
    for (int j = 0; j < 3; j++) begin
      io.stop = 1'b1;
      tick();
      io.stop = 1'b0;
      io.start = 1'b1;
      tick();
      io.start = 1'b0;
      x0 = int'(io.x_pos);
      c = 0;
      while (c < 20 && int'(io.x_pos) == x0) begin
        tick();
        c++;
      end
      chk($sformatf("spacing%0d", j), c, exp_sp[j]);
    end

    // asynchronous reset mid-sweep
    tick();
    tick();
    resetn = 1'b0;
    #1;
    chk("areset.x", int'(io.x_pos), 0);
    chk("areset.mov", int'(io.moving), 0);
    chk("areset.pulse", int'(io.stop_pulse), 0);
    chk("areset.w", int'(io.row_w), 0);
    tick();
    resetn = 1'b1;

    // random stimulus against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      st = ($urandom_range(0, 24) == 0);
      sp = ($urandom_range(0, 59) == 0);
      en = ($urandom_range(0, 9) != 0);
      nb = int'($urandom_range(0, 7));
      io.start      = st;
      io.stop       = sp;
      io.enable     = en;
      io.num_blocks = 3'(nb);
      tick();
      model_clock(st, sp, en, nb);
      got = {int'(io.x_pos), 14'(io.row_w), io.dir,
             io.moving, io.stopped, io.stop_pulse} ;
      exp = (m_x << 18) | ((m_nb * BW) << 4) | (m_dir << 3) |
            ((m_mode == 1) << 2) | ((m_mode == 2) << 1) | m_pulse;
      got = (int'(io.x_pos) << 18) | (int'(io.row_w) << 4) |
            (int'(io.dir) << 3) | (int'(io.moving) << 2) |
            (int'(io.stopped) << 1) | int'(io.stop_pulse);
      chk($sformatf("rand%0d", i), got, exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
